// File: rtl/frog_tracker.sv
// Frogger-style position tracker. The frog moves on rising button edges,
// loses a life on a lit hazard, scores on reaching row 0 and ends in OVER.
module frog_tracker #(
    parameter int ROWS  = 8,
    parameter int COLS  = 10,
    parameter int LIVES = 3,
    parameter int SCW   = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         L,
    input  logic                         R,
    input  logic                         U,
    input  logic                         D,
    input  logic [ROWS*COLS-1:0]         hazard_map,
    output logic [ROWS*COLS-1:0]         frog_map,
    output logic [$clog2(LIVES+1)-1:0]   lives_left,
    output logic [SCW-1:0]               score,
    output logic                         gameover
);

    localparam int NCELL = ROWS * COLS;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int LW    = $clog2(LIVES + 1);

    localparam logic [RW-1:0]  SPAWN_ROW = RW'(ROWS - 1);
    localparam logic [CW-1:0]  SPAWN_COL = CW'(COLS / 2);
    localparam logic [RW-1:0]  LAST_ROW  = RW'(ROWS - 1);
    localparam logic [CW-1:0]  LAST_COL  = CW'(COLS - 1);
    localparam logic [LW-1:0]  LIVES_INIT = LW'(LIVES);
    localparam logic [SCW-1:0] SCORE_MAX = {SCW{1'b1}};

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [LW-1:0]   lives_q, lives_d;
    logic [SCW-1:0]  score_q, score_d;
    logic [3:0]      btn_prev_q, btn_prev_d;

    logic [3:0]      btn_now;
    logic [3:0]      btn_rise;
    logic            single_move;
    logic [RW-1:0]   row_move;
    logic [CW-1:0]   col_move;
    logic [NCELL-1:0] cell_sel;
    logic            hazard_here;
    logic            at_goal;

    // Button order in the vectors below is {L, R, U, D}.
    assign btn_now = {L, R, U, D};

    always_comb begin
        btn_prev_d = btn_now;
        btn_rise   = btn_now & ~btn_prev_q;
    end

    // Exactly one rising edge is a move; simultaneous edges cancel out.
    always_comb begin
        single_move = 1'b0;
        case (btn_rise)
            4'b1000, 4'b0100, 4'b0010, 4'b0001: single_move = 1'b1;
            default:                            single_move = 1'b0;
        endcase
    end

    always_comb begin
        row_move = row_q;
        col_move = col_q;
        if (single_move) begin
            if (btn_rise[3] && (col_q != '0)) begin
                col_move = col_q - CW'(1);
            end
            if (btn_rise[2] && (col_q != LAST_COL)) begin
                col_move = col_q + CW'(1);
            end
            if (btn_rise[1] && (row_q != '0)) begin
                row_move = row_q - RW'(1);
            end
            if (btn_rise[0] && (row_q != LAST_ROW)) begin
                row_move = row_q + RW'(1);
            end
        end
    end

    // One-hot decode of the registered position, shared by display and collision.
    generate
        for (genvar gi = 0; gi < NCELL; gi++) begin : g_cell
            assign cell_sel[gi] = (row_q == RW'(gi / COLS)) && (col_q == CW'(gi % COLS));
        end
    endgenerate

    assign hazard_here = |(hazard_map & cell_sel);
    assign at_goal     = (row_q == '0);

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lives_d = lives_q;
        score_d = score_q;

        case (state_q)
            ST_PLAY: begin
                if (hazard_here) begin
                    state_d = ST_HIT;
                    if (lives_q != '0) begin
                        lives_d = lives_q - LW'(1);
                    end
                end else if (at_goal) begin
                    if (score_q != SCORE_MAX) begin
                        score_d = score_q + SCW'(1);
                    end
                    row_d = SPAWN_ROW;
                    col_d = SPAWN_COL;
                end else begin
                    row_d = row_move;
                    col_d = col_move;
                end
            end
            ST_HIT: begin
                if (lives_q == '0) begin
                    state_d = ST_OVER;
                end else begin
                    state_d = ST_PLAY;
                    row_d   = SPAWN_ROW;
                    col_d   = SPAWN_COL;
                end
            end
            ST_OVER: begin
                state_d = ST_OVER;
            end
            default: begin
                state_d = ST_PLAY;
            end
        endcase
    end

    // Prev registers load ones on reset so a button held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_PLAY;
            row_q      <= SPAWN_ROW;
            col_q      <= SPAWN_COL;
            lives_q    <= LIVES_INIT;
            score_q    <= '0;
            btn_prev_q <= 4'b1111;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            lives_q    <= lives_d;
            score_q    <= score_d;
            btn_prev_q <= btn_prev_d;
        end
    end

    assign frog_map   = (state_q == ST_PLAY) ? cell_sel : '0;
    assign lives_left = lives_q;
    assign score      = score_q;
    assign gameover   = (state_q == ST_OVER);

endmodule

// File: tb/tb_frog_tracker.sv
// Directed bench for frog_tracker: a game-level model checked every cycle,
// plus literal expectations pinning the model at key points.
module tb_frog_tracker;

    localparam int ROWS  = 8;
    localparam int COLS  = 10;
    localparam int LIVES = 3;
    localparam int SCW   = 8;
    localparam int N     = ROWS * COLS;

    localparam logic [3:0] B_L = 4'b1000;
    localparam logic [3:0] B_R = 4'b0100;
    localparam logic [3:0] B_U = 4'b0010;
    localparam logic [3:0] B_D = 4'b0001;

    logic clk;
    logic reset;
    logic L, R, U, D;
    logic [N-1:0] hazard_map;
    logic [N-1:0] frog_map;
    logic [1:0]   lives_left;
    logic [SCW-1:0] score;
    logic         gameover;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    // Game model: state 0 = playing, 1 = just hit, 2 = game over.
    int m_state, m_row, m_col, m_lives, m_score;
    logic [3:0] m_prev;

    frog_tracker #(.ROWS(ROWS), .COLS(COLS), .LIVES(LIVES), .SCW(SCW)) dut (
        .clk(clk), .reset(reset), .L(L), .R(R), .U(U), .D(D),
        .hazard_map(hazard_map), .frog_map(frog_map),
        .lives_left(lives_left), .score(score), .gameover(gameover)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_update(input logic [3:0] b, input logic rst, input logic [N-1:0] haz);
        logic [3:0] rise;
        if (rst) begin
            m_state = 0; m_row = ROWS - 1; m_col = COLS / 2;
            m_lives = LIVES; m_score = 0; m_prev = 4'b1111;
            return;
        end
        rise = b & ~m_prev;
        m_prev = b;
        if (m_state == 0) begin
            if (haz[m_row * COLS + m_col]) begin
                m_state = 1;
                m_lives = m_lives - 1;
            end else if (m_row == 0) begin
                m_score = (m_score + 1 > 255) ? 255 : m_score + 1;
                m_row = ROWS - 1; m_col = COLS / 2;
            end else if ($countones(rise) == 1) begin
                if (rise == B_L && m_col > 0)        m_col--;
                if (rise == B_R && m_col < COLS - 1) m_col++;
                if (rise == B_U && m_row > 0)        m_row--;
                if (rise == B_D && m_row < ROWS - 1) m_row++;
            end
        end else if (m_state == 1) begin
            if (m_lives == 0) m_state = 2;
            else begin
                m_state = 0; m_row = ROWS - 1; m_col = COLS / 2;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] exp_map;
            exp_map = '0;
            if (m_state == 0) exp_map[m_row * COLS + m_col] = 1'b1;
            checks++;
            if (frog_map !== exp_map) begin
                errors++;
                $display("FAIL model_frog_map t=%0t got=%h want=%h", $time, frog_map, exp_map);
            end
            checks++;
            if (int'(lives_left) != m_lives) begin
                errors++;
                $display("FAIL model_lives t=%0t got=%0d want=%0d", $time, lives_left, m_lives);
            end
            checks++;
            if (int'(score) != m_score) begin
                errors++;
                $display("FAIL model_score t=%0t got=%0d want=%0d", $time, score, m_score);
            end
            checks++;
            if (gameover !== (m_state == 2)) begin
                errors++;
                $display("FAIL model_gameover t=%0t got=%0b want=%0b", $time, gameover, m_state == 2);
            end
        end
    end

    // One cycle: drive inputs, let the edge happen, advance the model, return at the falling edge.
    task automatic step(input logic [3:0] b, input logic rst);
        {L, R, U, D} = b;
        reset = rst;
        @(posedge clk);
        model_update(b, rst, hazard_map);
        @(negedge clk);
        $display("step t=%0t btn=%b rst=%0b frog=%h lives=%0d score=%0d over=%0b",
                 $time, b, rst, frog_map, lives_left, score, gameover);
    endtask

    task automatic pulse(input logic [3:0] b);
        step(b, 1'b0);
        step(4'b0000, 1'b0);
    endtask

    task automatic do_reset();
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
    endtask

    // Literal check: the frog at one bit, or -1 for an empty map.
    task automatic chk_map(input string name, input int bitpos);
        logic [N-1:0] want;
        want = '0;
        if (bitpos >= 0) want[bitpos] = 1'b1;
        checks++;
        if (frog_map !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, frog_map, want);
        end
    endtask

    task automatic chk_val(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    initial begin
        {L, R, U, D} = 4'b0000;
        reset = 1'b1;
        hazard_map = '0;

        step(4'b0000, 1'b1);
        chk_en = 1;
        do_reset();
        chk_map("reset_spawn", 75);
        chk_val("reset_lives", int'(lives_left), 3);
        chk_val("reset_score", int'(score), 0);
        chk_val("reset_gameover", int'(gameover), 0);

        // Single U press moves one row; holding it adds nothing.
        step(B_U, 1'b0);
        chk_map("u_pulse", 65);
        step(B_U, 1'b0);
        step(B_U, 1'b0);
        chk_map("u_hold", 65);
        step(4'b0000, 1'b0);

        // Simultaneous edges are ignored; D at bottom row is blocked.
        do_reset();
        step(B_L | B_R, 1'b0);
        chk_map("l_and_r", 75);
        step(4'b0000, 1'b0);
        step(B_U | B_L, 1'b0);
        chk_map("u_and_l", 75);
        step(4'b0000, 1'b0);
        pulse(B_D);
        chk_map("d_bottom", 75);

        // Right wall.
        for (int i = 0; i < 4; i++) pulse(B_R);
        chk_map("right_edge", 79);
        pulse(B_R);
        chk_map("right_blocked", 79);

        // Left wall, then climb to goal.
        do_reset();
        for (int i = 0; i < 5; i++) pulse(B_L);
        chk_map("left_edge", 70);
        pulse(B_L);
        chk_map("left_blocked", 70);
        for (int i = 0; i < 6; i++) pulse(B_U);
        step(B_U, 1'b0);
        chk_map("at_goal", 0);
        step(4'b0000, 1'b0);
        chk_map("goal_respawn", 75);
        chk_val("goal_score", int'(score), 1);
        pulse(B_U);
        chk_map("goal_first_move", 65);

        // Three hazard hits lead to game over.
        do_reset();
        for (int h = 0; h < 3; h++) begin
            hazard_map = '0;
            hazard_map[75] = 1'b1;
            step(4'b0000, 1'b0);
            chk_map("hit_blank", -1);
            chk_val("hit_lives", int'(lives_left), 2 - h);
            hazard_map = '0;
            step(4'b0000, 1'b0);
        end
        chk_map("over_blank", -1);
        chk_val("over_flag", int'(gameover), 1);
        hazard_map = '1;
        pulse(B_U);
        pulse(B_L);
        chk_val("over_frozen_lives", int'(lives_left), 0);
        chk_val("over_still", int'(gameover), 1);
        hazard_map = '0;
        do_reset();
        chk_val("over_reset_lives", int'(lives_left), 3);
        chk_val("over_reset_score", int'(score), 0);
        chk_val("over_reset_flag", int'(gameover), 0);

        // U held through reset release must not move the frog.
        step(B_U, 1'b1);
        step(B_U, 1'b1);
        step(B_U, 1'b0);
        step(B_U, 1'b0);
        chk_map("held_through_reset", 75);
        step(4'b0000, 1'b0);

        // Reset while in HIT returns to a fresh game.
        hazard_map[75] = 1'b1;
        step(4'b0000, 1'b0);
        chk_map("hit_before_reset", -1);
        hazard_map = '0;
        step(4'b0000, 1'b1);
        chk_map("reset_from_hit", 75);
        chk_val("reset_from_hit_lives", int'(lives_left), 3);
        step(4'b0000, 1'b0);

        // Score saturation at 255.
        for (int g = 0; g < 257; g++) begin
            for (int i = 0; i < 7; i++) pulse(B_U);
        end
        chk_val("score_saturated", int'(score), 255);

        // Mixed walk with occasional hazards, checked against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            hazard_map = '0;
            if ($urandom_range(0, 11) == 0) hazard_map[$urandom_range(0, N - 1)] = 1'b1;
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 99) == 0));
        end

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
